pixel_array_ctrl: RTL and testbench
===================================

PIXEL_ARRAY_CTRL -- requirements
Module: pixel_array_ctrl

Interface
REQ-001 SHALL have parameter ERASE_CYC, default 5: cycles ERASE/RESET held high; legal range 1..255.
REQ-002 SHALL have parameter EXPOSE_CYC, default 255: cycles EXPOSE held high; legal range 1..65535.
REQ-003 SHALL have parameter CONVERT_CYC, default 256: cycles of the ramp/count phase; legal range 1..256.
REQ-004 SHALL have parameter READ_CYC, default 3: cycles each READn is held high; legal range 2..15.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, level request to run one frame.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have ports ERASE, EXPOSE, RESET, output, 1 each: pixel-array control strobes.
REQ-010 SHALL have port ramp_en, output, 1, enables the external analog ramp.
REQ-011 SHALL have port READ, output, 4, one-hot pixel select (bit n drives READ(n+1)).
REQ-012 SHALL have port cnt_out, output, 8, counter value for the shared COUNTER bus.
REQ-013 SHALL have port cnt_oe, output, 1, bus-drive enable for cnt_out (tristate at top level).
REQ-014 SHALL have port data_in, input, 8, COUNTER bus value as seen by the controller.
REQ-015 SHALL have port pix_data, output, 8; pix_idx, output, 2; pix_valid, output, 1: captured pixel result.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse at end of frame.

Function
REQ-017 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ with a single cycle counter for state durations.
REQ-018 SHALL move IDLE->ERASE on the first clk edge with start=1; start is ignored outside IDLE.
REQ-019 SHALL hold ERASE=1 and RESET=1 for exactly ERASE_CYC cycles, then enter EXPOSE.
REQ-020 SHALL hold EXPOSE=1 for exactly EXPOSE_CYC cycles, then enter CONVERT.
REQ-021 SHALL in CONVERT assert ramp_en=1 and cnt_oe=1, with cnt_out=0 on the first cycle, incrementing by 1 per cycle, for CONVERT_CYC cycles; with 256 cycles the last value is 255 and no wrap is ever driven.
REQ-022 SHALL in READ assert READ one-hot for pixel 0,1,2,3 in order, each for READ_CYC cycles, with cnt_oe=0 throughout.
REQ-023 SHALL sample data_in on the last cycle of each READ window and present pix_data, pix_idx and pix_valid=1 for one cycle on the following cycle.
REQ-024 SHALL, after the pix_valid for pixel 3, pulse frame_done for one cycle and, in that same cycle, be in IDLE with busy=0.
REQ-025 SHALL start a new frame on the cycle after frame_done when start is still high (back-to-back frames, one IDLE cycle).
REQ-026 SHALL never assert more than one of ERASE, EXPOSE, ramp_en or any READ bit in the same cycle, and never assert cnt_oe while any READ bit is high.
REQ-027 SHALL register every output; no output is combinational from any input.

Reset
REQ-028 SHALL on reset=1 at any clk edge, including mid-frame, enter IDLE and force ERASE=0, EXPOSE=0, RESET=0, ramp_en=0, READ=0000, cnt_out=0, cnt_oe=0, pix_data=0, pix_idx=0, pix_valid=0, frame_done=0, busy=0.
REQ-029 SHALL require start to be sampled afresh after reset; a start held through reset begins a frame on the first cycle after reset deasserts.

Structure
REQ-030 SHALL define the state enum and the default phase lengths in a shared package, pixel_ctrl_pkg.
REQ-031 SHALL be one module; the readout sequencer may be a single sub-module, pixel_readout_seq, owning READ, the pix_* outputs and frame_done.

Verification
REQ-032 Reset, then start=1 for one cycle -> ERASE high 5 cycles, EXPOSE high 255, ramp_en high 256 with cnt_out 0..255, READ 0001/0010/0100/1000 for 3 cycles each.
REQ-033 Bus model returning 0x11,0x22,0x33,0x44 per READ bit -> pix_valid four times with (idx,data) = (0,0x11),(1,0x22),(2,0x33),(3,0x44), then frame_done.
REQ-034 start held high for 2 frames -> exactly one IDLE cycle between frame_done and the next ERASE; busy low only in that cycle.
REQ-035 reset asserted in cycle 100 of CONVERT -> next cycle all outputs at reset values, cnt_oe=0; a new start gives a full, correct frame.
REQ-036 start pulsed during EXPOSE -> ignored; exactly one frame_done.
REQ-037 Every cycle of all runs -> exclusivity assertions of REQ-026 hold; cnt_out never wraps past 255 while cnt_oe=1.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and default phase lengths for the pixel-array controller.
package pixel_ctrl_pkg;

    localparam int unsigned DEF_ERASE_CYC   = 5;
    localparam int unsigned DEF_EXPOSE_CYC  = 255;
    localparam int unsigned DEF_CONVERT_CYC = 256;
    localparam int unsigned DEF_READ_CYC    = 3;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PIX_N  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned RCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } pix_result_t;

    // Terminal count for a phase that lasts n cycles starting from zero.
    function automatic logic [CNT_W-1:0] last_cyc(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/pixel_readout_seq.sv
// Walks the four READ windows, captures the COUNTER bus at the end of each,
// and signals end of frame one cycle after the last capture.
module pixel_readout_seq
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned READ_CYC = DEF_READ_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [PIX_N-1:0]  read_o,
    output logic [DATA_W-1:0] pix_data_o,
    output logic [IDX_W-1:0]  pix_idx_o,
    output logic              pix_valid_o,
    output logic              frame_done_o
);

    localparam logic [RCNT_W-1:0] RD_LAST  = RCNT_W'(READ_CYC - 1);
    localparam logic [IDX_W-1:0]  PIX_LAST = IDX_W'(PIX_N - 1);

    logic              active_q;
    logic [RCNT_W-1:0] rcnt_q;
    logic [IDX_W-1:0]  sel_q;
    logic [PIX_N-1:0]  read_q;
    pix_result_t       res_q;
    logic              valid_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            rcnt_q   <= '0;
            sel_q    <= '0;
            read_q   <= '0;
            res_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= valid_q && (res_q.idx == PIX_LAST);
            if (go_i) begin
                active_q <= 1'b1;
                rcnt_q   <= '0;
                sel_q    <= '0;
                read_q   <= PIX_N'(1);
            end else if (active_q) begin
                if (rcnt_q == RD_LAST) begin
                    // Capture while the selected pixel is still driving the bus.
                    res_q.data <= data_i;
                    res_q.idx  <= sel_q;
                    valid_q    <= 1'b1;
                    rcnt_q     <= '0;
                    if (sel_q == PIX_LAST) begin
                        active_q <= 1'b0;
                        read_q   <= '0;
                    end else begin
                        sel_q  <= sel_q + IDX_W'(1);
                        read_q <= read_q << 1;
                    end
                end else begin
                    rcnt_q <= rcnt_q + RCNT_W'(1);
                end
            end
        end
    end

    assign read_o       = read_q;
    assign pix_data_o   = res_q.data;
    assign pix_idx_o    = res_q.idx;
    assign pix_valid_o  = valid_q;
    assign frame_done_o = done_q;

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a 4-pixel array: erase, expose, ramp conversion,
// then hands off to the readout sequencer. All outputs are registered.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned ERASE_CYC   = DEF_ERASE_CYC,
    parameter int unsigned EXPOSE_CYC  = DEF_EXPOSE_CYC,
    parameter int unsigned CONVERT_CYC = DEF_CONVERT_CYC,
    parameter int unsigned READ_CYC    = DEF_READ_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              ERASE,
    output logic              EXPOSE,
    output logic              RESET,
    output logic              ramp_en,
    output logic [PIX_N-1:0]  READ,
    output logic [DATA_W-1:0] cnt_out,
    output logic              cnt_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] pix_data,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_valid,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] ERASE_LAST  = last_cyc(ERASE_CYC);
    localparam logic [CNT_W-1:0] EXPOSE_LAST = last_cyc(EXPOSE_CYC);
    localparam logic [CNT_W-1:0] CONV_LAST   = last_cyc(CONVERT_CYC);
    localparam logic [IDX_W-1:0] PIX_LAST    = IDX_W'(PIX_N - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cyc_q;
    logic              busy_q;
    logic              erase_q;
    logic              expose_q;
    logic              ramp_q;
    logic              oe_q;
    logic [DATA_W-1:0] cnt_out_q;

    logic rd_go;
    logic rd_last;

    // Readout starts on the same edge that ends conversion; the frame ends
    // on the edge that retires the last pixel's valid cycle.
    assign rd_go   = (state_q == ST_CONVERT) && (cyc_q == CONV_LAST);
    assign rd_last = pix_valid && (pix_idx == PIX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            busy_q    <= 1'b0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            ramp_q    <= 1'b0;
            oe_q      <= 1'b0;
            cnt_out_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ERASE;
                        cyc_q   <= '0;
                        busy_q  <= 1'b1;
                        erase_q <= 1'b1;
                    end
                end
                ST_ERASE: begin
                    if (cyc_q == ERASE_LAST) begin
                        state_q  <= ST_EXPOSE;
                        cyc_q    <= '0;
                        erase_q  <= 1'b0;
                        expose_q <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                    end
                end
                ST_EXPOSE: begin
                    if (cyc_q == EXPOSE_LAST) begin
                        state_q   <= ST_CONVERT;
                        cyc_q     <= '0;
                        expose_q  <= 1'b0;
                        ramp_q    <= 1'b1;
                        oe_q      <= 1'b1;
                        cnt_out_q <= '0;
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                    end
                end
                ST_CONVERT: begin
                    // Ramp count tracks the cycle index, so it stops at
                    // CONVERT_CYC-1 and never wraps while driven.
                    if (cyc_q == CONV_LAST) begin
                        state_q   <= ST_READ;
                        cyc_q     <= '0;
                        ramp_q    <= 1'b0;
                        oe_q      <= 1'b0;
                        cnt_out_q <= '0;
                    end else begin
                        cyc_q     <= cyc_q + CNT_W'(1);
                        cnt_out_q <= cnt_out_q + DATA_W'(1);
                    end
                end
                ST_READ: begin
                    if (rd_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign ERASE   = erase_q;
    assign RESET   = erase_q;
    assign EXPOSE  = expose_q;
    assign ramp_en = ramp_q;
    assign cnt_oe  = oe_q;
    assign cnt_out = cnt_out_q;

    pixel_readout_seq #(
        .READ_CYC (READ_CYC)
    ) u_readout (
        .clk          (clk),
        .reset        (reset),
        .go_i         (rd_go),
        .data_i       (data_in),
        .read_o       (READ),
        .pix_data_o   (pix_data),
        .pix_idx_o    (pix_idx),
        .pix_valid_o  (pix_valid),
        .frame_done_o (frame_done)
    );

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench: frame-position reference model compared every cycle.
module tb_pixel_array_ctrl;

    localparam int E      = 5;
    localparam int X      = 255;
    localparam int C      = 256;
    localparam int RC     = 3;
    localparam int R0     = E + X + C;
    localparam int DONE_K = R0 + 4 * RC + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic       busy, erase_o, expose_o, reset_o, ramp_en, cnt_oe;
    logic       pix_valid, frame_done;
    logic [3:0] read_o;
    logic [7:0] cnt_out, pix_data;
    logic [1:0] pix_idx;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    // Model: pos = -1 idle, 0..DONE_K = cycle index within the current frame.
    int         pos       = -1;
    logic       after_rst = 1'b0;
    logic       fixed_bus = 1'b0;
    logic [7:0] bus_val [4];

    always #5 clk = ~clk;

    pixel_array_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .ERASE      (erase_o),
        .EXPOSE     (expose_o),
        .RESET      (reset_o),
        .ramp_en    (ramp_en),
        .READ       (read_o),
        .cnt_out    (cnt_out),
        .cnt_oe     (cnt_oe),
        .data_in    (data_in),
        .pix_data   (pix_data),
        .pix_idx    (pix_idx),
        .pix_valid  (pix_valid),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, pos, obs, exp);
        end
    endtask

    task automatic step();
        logic       e_busy, e_erase, e_expose, e_ramp, e_valid, e_done;
        logic [3:0] e_read;
        logic [7:0] e_cnt, e_data;
        logic [1:0] e_idx;
        @(posedge clk);
        if (reset) begin
            pos       = -1;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (pos == -1 || pos == DONE_K) begin
                if (start) begin
                    pos = 0;
                    for (int i = 0; i < 4; i++)
                        bus_val[i] = fixed_bus ? 8'((i + 1) * 8'h11) : 8'($urandom);
                end else begin
                    pos = -1;
                end
            end else begin
                pos++;
            end
        end
        #1;
        e_busy   = (pos >= 0) && (pos < DONE_K);
        e_erase  = (pos >= 0) && (pos < E);
        e_expose = (pos >= E) && (pos < E + X);
        e_ramp   = (pos >= E + X) && (pos < R0);
        e_cnt    = e_ramp ? 8'(pos - (E + X)) : 8'h00;
        e_read   = (pos >= R0 && pos < R0 + 4 * RC) ? 4'(1 << ((pos - R0) / RC)) : 4'b0000;
        e_valid  = (pos > R0) && (pos <= R0 + 4 * RC) && (((pos - R0) % RC) == 0);
        e_idx    = e_valid ? 2'((pos - R0) / RC - 1) : 2'd0;
        e_data   = e_valid ? bus_val[e_idx] : 8'h00;
        e_done   = (pos == DONE_K);

        chk("busy", 16'(busy), 16'(e_busy));
        chk("ERASE", 16'(erase_o), 16'(e_erase));
        chk("RESET", 16'(reset_o), 16'(e_erase));
        chk("EXPOSE", 16'(expose_o), 16'(e_expose));
        chk("ramp_en", 16'(ramp_en), 16'(e_ramp));
        chk("cnt_oe", 16'(cnt_oe), 16'(e_ramp));
        chk("READ", 16'(read_o), 16'(e_read));
        chk("pix_valid", 16'(pix_valid), 16'(e_valid));
        chk("frame_done", 16'(frame_done), 16'(e_done));
        if (e_ramp || after_rst) chk("cnt_out", 16'(cnt_out), 16'(e_cnt));
        if (e_valid || after_rst) begin
            chk("pix_data", 16'(pix_data), 16'(e_data));
            chk("pix_idx", 16'(pix_idx), 16'(e_idx));
        end
        chk("strobe_excl", 16'($onehot0({erase_o, expose_o, ramp_en, read_o})), 16'(1));
        chk("oe_vs_read", 16'(cnt_oe && (|read_o)), 16'(0));
        if (frame_done === 1'b1) n_done++;

        case (read_o)
            4'b0001: data_in = bus_val[0];
            4'b0010: data_in = bus_val[1];
            4'b0100: data_in = bus_val[2];
            4'b1000: data_in = bus_val[3];
            default: data_in = 8'($urandom);
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;
        for (int i = 0; i < 4; i++) bus_val[i] = 8'h00;

        // Reset values.
        run(3);
        reset = 1'b0;
        run(2);

        // Single frame with fixed bus values; a start pulse during EXPOSE is ignored.
        fixed_bus = 1'b1;
        n_done    = 0;
        start     = 1'b1;
        step();
        start = 1'b0;
        run(100);
        start = 1'b1;
        step();
        start = 1'b0;
        run(DONE_K + 5);
        chk("one_frame_done", 16'(n_done), 16'(1));
        fixed_bus = 1'b0;

        // Back-to-back frames with start held high.
        n_done = 0;
        start  = 1'b1;
        run(2 * (DONE_K + 1) + 3);
        start = 1'b0;
        run(DONE_K + 3);
        chk("b2b_frame_count", 16'(n_done), 16'(3));

        // Reset in cycle 100 of CONVERT, then a full frame.
        start = 1'b1;
        step();
        start = 1'b0;
        run(E + X + 100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(3);
        n_done = 0;
        start  = 1'b1;
        step();
        start = 1'b0;
        run(DONE_K + 3);
        chk("post_reset_frame", 16'(n_done), 16'(1));

        // Random start/reset traffic.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        start = 1'b0;
        reset = 1'b0;
        run(DONE_K + 2);

        // Start held through reset begins a frame right after reset drops.
        start = 1'b1;
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        step();
        start = 1'b0;
        run(DONE_K + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
